// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module : clk_div_bank_if
// Control/status bundle for the clock divider bank (enables, sync, writes).
// Rev    : 1.0
// ============================================================================
interface clk_div_bank_if #(
    parameter int N_CH      = 2,
    parameter int CTR_WIDTH = 7
);
    localparam int CH_W = $clog2(N_CH) + 1;

    logic [N_CH-1:0]      ch_en;
    logic                 sync;
    logic                 wr_en;
    logic [CH_W-1:0]      wr_ch;
    logic [CTR_WIDTH-1:0] wr_div;
    logic [N_CH-1:0]      clk_out;
    logic [N_CH-1:0]      tick;

    modport master (
        output ch_en, sync, wr_en, wr_ch, wr_div,
        input  clk_out, tick
    );

    modport slave (
        input  ch_en, sync, wr_en, wr_ch, wr_div,
        output clk_out, tick
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module : clk_div_bank
// N-channel 50% duty clock divider with programmable divisors and phase sync.
// Rev    : 1.0
// ============================================================================
module clk_div_bank #(
    parameter int                          N_CH      = 2,
    parameter int                          CTR_WIDTH = 7,
    parameter logic [N_CH*CTR_WIDTH-1:0]   DIV_INIT  = {7'd28, 7'd2}
) (
    input  wire logic           clk_i,
    input  wire logic           rst_n_i,
    clk_div_bank_if.slave       bus
);

    localparam logic [CTR_WIDTH-1:0] c_CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            localparam logic [CTR_WIDTH-1:0] c_DIV_RST = DIV_INIT[i*CTR_WIDTH +: CTR_WIDTH];

            logic [CTR_WIDTH-1:0] cnt_q, cnt_d;
            logic [CTR_WIDTH-1:0] pend_q, pend_d;
            logic                 out_q, out_d;
            logic                 tick_q, tick_d;
            logic                 wr_hit;

            // Out-of-range channel indices never match any i, so they are dropped.
            assign wr_hit = bus.wr_en && (int'(bus.wr_ch) == i);

            always_comb begin
                pend_d = pend_q;
                cnt_d  = cnt_q;
                out_d  = out_q;
                tick_d = 1'b0;

                if (wr_hit) begin
                    pend_d = bus.wr_div;
                end

                if (bus.sync) begin
                    cnt_d = pend_q;
                    out_d = 1'b0;
                end else if (bus.ch_en[i] || out_q) begin
                    // Reload from pend_q only here so a divisor change never cuts a half-period short.
                    if (cnt_q == '0) begin
                        out_d  = ~out_q;
                        cnt_d  = pend_q;
                        tick_d = ~out_q;
                    end else begin
                        cnt_d = cnt_q - c_CTR_ONE;
                    end
                end else begin
                    cnt_d = pend_d;
                end
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    cnt_q  <= c_DIV_RST;
                    pend_q <= c_DIV_RST;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    pend_q <= pend_d;
                    out_q  <= out_d;
                    tick_q <= tick_d;
                end
            end

            assign bus.clk_out[i] = out_q;
            assign bus.tick[i]    = tick_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_clk_div_bank
// Directed self-checking bench for clk_div_bank (2 channels, default divisors).
// Rev    : 1.0
// ============================================================================
module tb_clk_div_bank;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_div_bank_if #(.N_CH(2), .CTR_WIDTH(7)) bus ();

    clk_div_bank #(
        .N_CH      (2),
        .CTR_WIDTH (7),
        .DIV_INIT  ({7'd28, 7'd2})
    ) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;
    int last_rise [2];
    int last_fall [2];
    int rise_cnt  [2];
    int tick_cnt  [2];
    int tick_err  = 0;
    logic [1:0] prev = 2'b00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock, then sample and record edges/ticks of both channels.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (bus.clk_out[c] && !prev[c]) begin
                last_rise[c] = cyc;
                rise_cnt[c]++;
            end
            if (!bus.clk_out[c] && prev[c]) last_fall[c] = cyc;
            if (bus.tick[c] !== (bus.clk_out[c] && !prev[c])) tick_err++;
            if (bus.tick[c] === 1'b1) tick_cnt[c]++;
        end
        prev = bus.clk_out;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic clear_mon();
        cyc  = 0;
        prev = 2'b00;
        for (int c = 0; c < 2; c++) begin
            last_rise[c] = -1;
            last_fall[c] = -1;
            rise_cnt[c]  = 0;
            tick_cnt[c]  = 0;
        end
    endtask

    task automatic set_write(input logic en, input logic [1:0] ch, input logic [6:0] div);
        bus.wr_en  = en;
        bus.wr_ch  = ch;
        bus.wr_div = div;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ch_en = 2'b11;
        bus.sync  = 1'b0;
        set_write(1'b0, 2'd0, 7'd0);
        clear_mon();

        // Reset state and default divisors (ch0 period 6, ch1 period 58)
        step();
        step();
        check_eq("rst_clk_out", bus.clk_out, 2'b00);
        check_eq("rst_tick", bus.tick, 2'b00);
        rst_n = 1'b1;
        clear_mon();
        run_to(60);
        check_eq("t1_ch0_rises", rise_cnt[0], 10);
        check_eq("t1_ch0_last_rise", last_rise[0], 57);
        check_eq("t1_ch0_last_fall", last_fall[0], 60);
        check_eq("t1_ch1_first_rise", last_rise[1], 29);
        check_eq("t1_ch1_first_fall", last_fall[1], 58);
        run_to(90);
        check_eq("t1_ch0_rises_90", rise_cnt[0], 15);
        check_eq("t1_ch0_ticks_90", tick_cnt[0], 15);
        check_eq("t1_ch1_second_rise", last_rise[1], 87);
        check_eq("t1_ch1_ticks_90", tick_cnt[1], 2);

        // Divisor write mid high phase
        run_to(93);
        check_eq("t2_ch0_rise", last_rise[0], 93);
        set_write(1'b1, 2'd0, 7'd5);
        run_to(94);
        set_write(1'b0, 2'd0, 7'd0);
        run_to(96);
        check_eq("t2_ch0_fall_old_len", last_fall[0], 96);
        run_to(102);
        check_eq("t2_ch0_rise_new_len", last_rise[0], 102);
        run_to(108);
        check_eq("t2_ch0_fall_new_len", last_fall[0], 108);

        // Write on the exact reload cycle
        run_to(113);
        set_write(1'b1, 2'd0, 7'd1);
        run_to(114);
        set_write(1'b0, 2'd0, 7'd0);
        check_eq("t3_ch0_rise", last_rise[0], 114);
        run_to(120);
        check_eq("t3_ch0_fall_old_len", last_fall[0], 120);
        run_to(122);
        check_eq("t3_ch0_rise_new_len", last_rise[0], 122);
        run_to(124);
        check_eq("t3_ch0_fall_new_len", last_fall[0], 124);

        // Restore ch0 divisor, then SYNC while both outputs high with a coincident write
        run_to(126);
        set_write(1'b1, 2'd0, 7'd2);
        run_to(127);
        set_write(1'b0, 2'd0, 7'd0);
        run_to(149);
        check_eq("t4_pre_sync_high", bus.clk_out, 2'b11);
        bus.sync = 1'b1;
        set_write(1'b1, 2'd1, 7'd10);
        run_to(150);
        bus.sync = 1'b0;
        set_write(1'b0, 2'd0, 7'd0);
        check_eq("t4_sync_clk_out", bus.clk_out, 2'b00);
        check_eq("t4_sync_tick", bus.tick, 2'b00);
        run_to(153);
        check_eq("t4_ch0_rise", last_rise[0], 153);
        run_to(179);
        check_eq("t4_ch1_rise_old_div", last_rise[1], 179);
        run_to(190);
        check_eq("t4_ch1_fall_new_div", last_fall[1], 190);

        // Disable ch0 while high, write while stopped, re-enable
        check_eq("t5_ch0_high", bus.clk_out[0], 1'b1);
        bus.ch_en = 2'b10;
        run_to(200);
        check_eq("t5_ch0_stopped", bus.clk_out[0], 1'b0);
        check_eq("t5_ch0_fall", last_fall[0], 192);
        check_eq("t5_ch0_no_rise", last_rise[0], 189);
        set_write(1'b1, 2'd0, 7'd3);
        run_to(201);
        set_write(1'b0, 2'd0, 7'd0);
        run_to(205);
        bus.ch_en = 2'b11;
        run_to(209);
        check_eq("t5_ch0_reenable_rise", last_rise[0], 209);
        check_eq("t5_ch0_reenable_tick", bus.tick[0], 1'b1);

        // Out-of-range channel write is ignored
        run_to(210);
        set_write(1'b1, 2'd2, 7'd0);
        run_to(211);
        set_write(1'b0, 2'd0, 7'd0);
        run_to(217);
        check_eq("t6_ch0_fall", last_fall[0], 213);
        check_eq("t6_ch0_rise", last_rise[0], 217);
        run_to(223);
        check_eq("t6_ch1_fall", last_fall[1], 212);
        check_eq("t6_ch1_rise", last_rise[1], 223);
        check_eq("tick_align", tick_err, 0);

        // Asynchronous reset mid-count: outputs clear without a clock edge, writes lost
        run_to(224);
        check_eq("t6_pre_rst_ch1_high", bus.clk_out[1], 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_rst_clk_out", bus.clk_out, 2'b00);
        check_eq("t6_async_rst_tick", bus.tick, 2'b00);
        run_to(226);
        rst_n = 1'b1;
        base = cyc;
        run_to(base + 3);
        check_eq("t6_post_rst_ch0_rise", last_rise[0], base + 3);
        run_to(base + 29);
        check_eq("t6_post_rst_ch1_rise", last_rise[1], base + 29);
        check_eq("t6_post_rst_ch0_period", last_rise[0], base + 27);
        check_eq("tick_align_final", tick_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
